// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Word-organised data RAM answering load/store requests from the core's
//   memory stage. A request is accepted while req_ready is high. The block
//   then waits WAIT_CYCLES cycles to model slow memory and returns a
//   one-cycle resp_valid pulse.
//   Misaligned accesses, out-of-range accesses and requests with both read
//   and write high are reported through resp_err. An erroring access never
//   touches the RAM.
//
// Ports
//   clk, reset              rising-edge clock, asynchronous active-high reset
//   req_read / req_write    load / store request (sampled while req_ready)
//   req_addr                byte address
//   req_wdata, req_be       store data and byte enables (be[i] -> byte i)
//   req_ready               high in IDLE only
//   resp_valid              one-cycle response pulse, no backpressure
//   resp_rdata, resp_err    load data / error flag, zero outside resp_valid
module data_mem_responder #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_read,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [3:0] LAST = 4'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } req_t;

  state_t            state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  req_t              live, lat, cur;
  logic              accept, commit, cur_err;
  logic [ADDR_W-1:0] idx;
  logic [31:0]       rdata_q;
  logic              err_q;
  logic [31:0]       mem [DEPTH];

  assign live   = '{rd: req_read, wr: req_write, addr: req_addr,
                    wdata: req_wdata, be: req_be};
  assign accept = (state == S_IDLE) && (req_read || req_write);

  // With zero wait states the commit happens on the acceptance edge itself,
  // before the latch is loaded. In that case the live request is the one
  // being committed.
  assign cur     = (state == S_IDLE) ? live : lat;
  assign cur_err = (cur.addr[1:0] != 2'b00) ||
                   ((cur.addr >> (ADDR_W + 2)) != 32'd0) ||
                   (cur.rd && cur.wr);
  assign idx     = cur.addr[ADDR_W+1:2];

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    commit    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          if (WAIT_CYCLES == 0) begin
            state_nxt = S_RESP;
            commit    = 1'b1;
          end else begin
            state_nxt = S_WAIT;
            cnt_nxt   = 4'd0;
          end
        end
      end
      S_WAIT: begin
        if (cnt == LAST) begin
          state_nxt = S_RESP;
          cnt_nxt   = 4'd0;
          commit    = 1'b1;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= 4'd0;
      lat     <= '0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) lat <= live;
      if (commit) begin
        err_q   <= cur_err;
        rdata_q <= (!cur_err && cur.rd) ? mem[idx] : 32'd0;
      end else if (state == S_RESP) begin
        err_q   <= 1'b0;
        rdata_q <= 32'd0;
      end
    end
  end

  // RAM is not reset. A store aborted by reset never reaches its commit edge,
  // so it is never written.
  always_ff @(posedge clk) begin
    if (commit && cur.wr && !cur_err) begin
      for (int i = 0; i < 4; i++) begin
        if (cur.be[i]) mem[idx][8*i +: 8] <= cur.wdata[8*i +: 8];
      end
    end
  end

  assign req_ready  = (state == S_IDLE);
  assign resp_valid = (state == S_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;
  localparam int W = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_read, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;

  logic        r1_read, r1_write;
  logic [31:0] r1_addr, r1_wdata;
  logic [3:0]  r1_be;
  logic        r1_ready, r1_valid, r1_err;
  logic [31:0] r1_rdata;

  always #5 clk = ~clk;

  data_mem_responder #(.ADDR_W(8), .WAIT_CYCLES(W)) u0 (
    .clk(clk), .reset(rst), .req_read(req_read), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err));

  data_mem_responder #(.ADDR_W(8), .WAIT_CYCLES(0)) u1 (
    .clk(clk), .reset(rst), .req_read(r1_read), .req_write(r1_write),
    .req_addr(r1_addr), .req_wdata(r1_wdata), .req_be(r1_be),
    .req_ready(r1_ready), .resp_valid(r1_valid), .resp_rdata(r1_rdata),
    .resp_err(r1_err));

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          due;
  } exp_t;

  exp_t        q[$];
  logic [31:0] model [256];
  int          cyc = 0;
  int          n_chk = 0, n_fail = 0, n_resp = 0;
  logic [31:0] last_rdata;
  logic        last_err;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: the reference memory is updated when a store response retires.
  exp_t        m_e;
  logic        m_err;
  logic [31:0] m_rd;
  always @(negedge clk) begin
    if (!rst) begin
      if (resp_valid) begin
        n_resp++;
        last_rdata = resp_rdata;
        last_err   = resp_err;
        if (q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_resp: resp_valid=1 at cycle %0d, nothing outstanding", cyc);
        end else begin
          m_e   = q.pop_front();
          m_err = (m_e.addr[1:0] != 2'b00) || (m_e.addr[31:10] != 22'd0) || (m_e.rd && m_e.wr);
          m_rd  = (!m_err && m_e.rd) ? model[m_e.addr[9:2]] : 32'd0;
          n_chk++;
          if (cyc !== m_e.due) begin
            n_fail++;
            $display("FAIL resp_latency: got cycle %0d, want %0d", cyc, m_e.due);
          end
          n_chk++;
          if (resp_err !== m_err) begin
            n_fail++;
            $display("FAIL resp_err @%h: got %b, want %b", m_e.addr, resp_err, m_err);
          end
          n_chk++;
          if (resp_rdata !== m_rd) begin
            n_fail++;
            $display("FAIL resp_rdata @%h: got %h, want %h", m_e.addr, resp_rdata, m_rd);
          end
          if (!m_err && m_e.wr)
            for (int i = 0; i < 4; i++)
              if (m_e.be[i]) model[m_e.addr[9:2]][8*i +: 8] = m_e.wdata[8*i +: 8];
        end
      end else begin
        n_chk++;
        if (resp_rdata !== 32'd0 || resp_err !== 1'b0) begin
          n_fail++;
          $display("FAIL idle_outputs: rdata=%h err=%b, want 0/0", resp_rdata, resp_err);
        end
      end
    end
  end

  task automatic wait_ready();
    int t = 0;
    @(negedge clk);
    while (!req_ready && t < 50) begin @(negedge clk); t++; end
    n_chk++;
    if (!req_ready) begin
      n_fail++;
      $display("FAIL ready_timeout: req_ready=%b after %0d cycles, want 1", req_ready, t);
    end
  endtask

  task automatic req(input logic rd, input logic wr, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] be);
    wait_ready();
    if (req_ready) begin
      req_read = rd; req_write = wr; req_addr = a; req_wdata = d; req_be = be;
      q.push_back('{rd, wr, a, d, be, cyc + 1 + W});
      @(posedge clk); #1;
      req_read = 1'b0; req_write = 1'b0;
    end
  endtask

  task automatic drain();
    int t = 0;
    while (q.size() != 0 && t < 60) begin @(negedge clk); #1; t++; end
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d responses outstanding, want 0", q.size());
      q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_read = 0; req_write = 0; req_addr = 0; req_wdata = 0; req_be = 0;
    r1_read = 0; r1_write = 0; r1_addr = 0; r1_wdata = 0; r1_be = 0;
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if ({req_ready, resp_valid, resp_rdata, resp_err} !== {1'b1, 1'b0, 32'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state: ready=%b valid=%b rdata=%h err=%b, want 1/0/0/0",
               req_ready, resp_valid, resp_rdata, resp_err);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    n_chk++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset: ready=%b valid=%b, want 1/0", req_ready, resp_valid);
    end
  endtask

  task automatic test_store_load();
    req(0, 1, 32'h10, 32'hDEADBEEF, 4'hF); drain();
    req(1, 0, 32'h10, 32'h0, 4'h0); drain();
    n_chk++;
    if (last_rdata !== 32'hDEADBEEF || last_err !== 1'b0) begin
      n_fail++;
      $display("FAIL store_load: rdata=%h err=%b, want deadbeef/0", last_rdata, last_err);
    end
  endtask

  task automatic test_byte_enable();
    req(0, 1, 32'h10, 32'h000000AA, 4'b0001); drain();
    req(1, 0, 32'h10, 32'h0, 4'b0011); drain();
    n_chk++;
    if (last_rdata !== 32'hDEADBEAA) begin
      n_fail++;
      $display("FAIL be_partial: rdata=%h, want deadbeaa", last_rdata);
    end
    req(0, 1, 32'h10, 32'h55555555, 4'b0000); drain();
    n_chk++;
    if (last_err !== 1'b0) begin
      n_fail++;
      $display("FAIL be_zero_err: err=%b, want 0", last_err);
    end
    req(1, 0, 32'h10, 32'h0, 4'h0); drain();
    n_chk++;
    if (last_rdata !== 32'hDEADBEAA) begin
      n_fail++;
      $display("FAIL be_zero_noop: rdata=%h, want deadbeaa", last_rdata);
    end
  endtask

  task automatic test_errors();
    logic [31:0] bad [2];
    bad[0] = 32'h13;
    bad[1] = 32'h400;
    for (int i = 0; i < 2; i++) begin
      req(1, 0, bad[i], 32'h0, 4'h0); drain();
      n_chk++;
      if (last_err !== 1'b1 || last_rdata !== 32'd0) begin
        n_fail++;
        $display("FAIL addr_err @%h: err=%b rdata=%h, want 1/0", bad[i], last_err, last_rdata);
      end
    end
    req(0, 1, 32'h410, 32'h99999999, 4'hF); drain();
    req(1, 0, 32'h10, 32'h0, 4'h0); drain();
    n_chk++;
    if (last_rdata !== 32'hDEADBEAA) begin
      n_fail++;
      $display("FAIL err_ram_intact: rdata=%h, want deadbeaa", last_rdata);
    end
    req(0, 1, 32'h20, 32'h11112222, 4'hF); drain();
    req(1, 1, 32'h20, 32'hFFFFFFFF, 4'hF); drain();
    n_chk++;
    if (last_err !== 1'b1 || last_rdata !== 32'd0) begin
      n_fail++;
      $display("FAIL rw_both: err=%b rdata=%h, want 1/0", last_err, last_rdata);
    end
    req(1, 0, 32'h20, 32'h0, 4'h0); drain();
    n_chk++;
    if (last_rdata !== 32'h11112222) begin
      n_fail++;
      $display("FAIL rw_both_nowrite: rdata=%h, want 11112222", last_rdata);
    end
  endtask

  task automatic test_back_to_back();
    int prev = 0;
    int r0 = n_resp;
    req_addr = 32'h10;
    req_be   = 4'h0;
    for (int i = 0; i < 4; i++) begin
      wait_ready();
      if (req_ready) begin
        req_read = 1'b1;
        q.push_back('{1'b1, 1'b0, 32'h10, 32'h0, 4'h0, cyc + 1 + W});
        if (i > 0) begin
          n_chk++;
          if (cyc - prev !== W + 2) begin
            n_fail++;
            $display("FAIL b2b_spacing: got %0d cycles, want %0d", cyc - prev, W + 2);
          end
        end
        prev = cyc;
      end
    end
    @(posedge clk); #1;
    req_read = 1'b0;
    drain();
    n_chk++;
    if (n_resp - r0 !== 4) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d pulses, want 4", n_resp - r0);
    end
  endtask

  task automatic test_reset_abort();
    int r0;
    req(0, 1, 32'h30, 32'hCAFEF00D, 4'hF); drain();
    wait_ready();
    req_write = 1'b1; req_addr = 32'h30; req_wdata = 32'h12345678; req_be = 4'hF;
    @(posedge clk); #1;
    req_write = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    n_chk++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_reset_state: ready=%b valid=%b, want 1/0", req_ready, resp_valid);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    r0 = n_resp;
    repeat (6) @(negedge clk);
    #1;
    n_chk++;
    if (n_resp !== r0) begin
      n_fail++;
      $display("FAIL abort_no_resp: got %0d pulses, want 0", n_resp - r0);
    end
    req(1, 0, 32'h30, 32'h0, 4'h0); drain();
    n_chk++;
    if (last_rdata !== 32'hCAFEF00D) begin
      n_fail++;
      $display("FAIL abort_no_write: rdata=%h, want cafef00d", last_rdata);
    end
  endtask

  task automatic test_wait0();
    logic [31:0] want [2];
    want[0] = 32'd0;
    want[1] = 32'h55AA55AA;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      r1_read = (i == 1); r1_write = (i == 0);
      r1_addr = 32'h40; r1_wdata = 32'h55AA55AA; r1_be = 4'hF;
      @(posedge clk); #1;
      r1_read = 1'b0; r1_write = 1'b0;
      n_chk++;
      if (r1_valid !== 1'b1 || r1_ready !== 1'b0 || r1_err !== 1'b0 || r1_rdata !== want[i]) begin
        n_fail++;
        $display("FAIL wait0_resp[%0d]: valid=%b ready=%b err=%b rdata=%h, want 1/0/0/%h",
                 i, r1_valid, r1_ready, r1_err, r1_rdata, want[i]);
      end
      @(posedge clk); #1;
      n_chk++;
      if (r1_valid !== 1'b0 || r1_ready !== 1'b1 || r1_rdata !== 32'd0) begin
        n_fail++;
        $display("FAIL wait0_after[%0d]: valid=%b ready=%b rdata=%h, want 0/1/0",
                 i, r1_valid, r1_ready, r1_rdata);
      end
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_byte_enable();
    test_errors();
    test_back_to_back();
    test_reset_abort();
    test_wait0();
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, want done");
    $fatal(1, "timeout");
  end

endmodule
